// File: rtl/pipe_hazard_ctrl_if.sv
// Control bundle between the fetch/decode/execute stages and pipe_hazard_ctrl.
// The master side is the pipeline; the slave side is the controller.
interface pipe_hazard_ctrl_if #(
    parameter int RA_W = 6
);
    logic            dec_valid;
    logic [RA_W-1:0] dec_selA;
    logic [4:0]      dec_selB;
    logic            dec_uses_b;
    logic [RA_W-1:0] ex_selOut;
    logic            ex_lam_new;
    logic            ex_lam_load;
    logic            ex_new_jmp;
    logic            lam_ack;
    logic            en_fetch;
    logic            en_dec;
    logic            bubble;
    logic            pc_load_jmp;
    logic            lam_req;
    logic            mem_err;
    logic            busy;

    modport master (
        output dec_valid, dec_selA, dec_selB, dec_uses_b, ex_selOut,
               ex_lam_new, ex_lam_load, ex_new_jmp, lam_ack,
        input  en_fetch, en_dec, bubble, pc_load_jmp, lam_req, mem_err, busy
    );

    modport slave (
        input  dec_valid, dec_selA, dec_selB, dec_uses_b, ex_selOut,
               ex_lam_new, ex_lam_load, ex_new_jmp, lam_ack,
        output en_fetch, en_dec, bubble, pc_load_jmp, lam_req, mem_err, busy
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Fetch/decode/execute sequencing: load-use stalls, lam req/ack with timeout, jump flush.
// Optional PIPE_HAZARD_PERF_CNT_EN adds saturating stall_cnt/flush_cnt outputs.
module pipe_hazard_ctrl #(
    parameter int FLUSH_CYCLES = 2,
    parameter int MEM_TIMEOUT  = 15,
    parameter int RA_W         = 6
) (
    input  logic              clk,
    input  logic              reset,
    pipe_hazard_ctrl_if.slave bus
`ifdef PIPE_HAZARD_PERF_CNT_EN
    ,
    output logic [15:0]       stall_cnt,
    output logic [15:0]       flush_cnt
`endif
);

    typedef enum logic [1:0] {RUN, MEM_WAIT, FLUSH} state_t;

    localparam logic [2:0] FLUSH_AFTER_JMP = 3'(FLUSH_CYCLES - 1);
    localparam logic [2:0] FLUSH_AFTER_MEM = 3'(FLUSH_CYCLES);
    localparam logic [7:0] TMO_LAST        = 8'(MEM_TIMEOUT - 1);

    state_t     state_q, state_d;
    logic [7:0] tmo_q, tmo_d;
    logic [2:0] fl_q, fl_d;
    logic       jmp_pending_q, jmp_pending_d;
    logic       lam_req_q, lam_req_d;

    logic            hz;
    logic [RA_W-1:0] sel_b_ext;
    logic            en_fetch_c, en_dec_c, bubble_c, pc_load_c, mem_err_c;

    assign sel_b_ext = RA_W'(bus.dec_selB);
    assign hz = bus.dec_valid & bus.ex_lam_new & bus.ex_lam_load & (bus.ex_selOut != '0) &
                ((bus.dec_selA == bus.ex_selOut) | (bus.dec_uses_b & (sel_b_ext == bus.ex_selOut)));

    // A jump served after a memory access gets one extra flush cycle because the
    // ack cycle itself only bubbles on a load-use hazard.
    always_comb begin
        state_d       = state_q;
        tmo_d         = tmo_q;
        fl_d          = fl_q;
        jmp_pending_d = jmp_pending_q;
        lam_req_d     = lam_req_q;
        en_fetch_c    = 1'b1;
        en_dec_c      = 1'b1;
        bubble_c      = 1'b0;
        pc_load_c     = 1'b0;
        mem_err_c     = 1'b0;
        case (state_q)
            RUN: begin
                if (bus.ex_lam_new) begin
                    en_fetch_c = 1'b0;
                    en_dec_c   = 1'b0;
                    lam_req_d  = 1'b1;
                    tmo_d      = '0;
                    state_d    = MEM_WAIT;
                    if (bus.ex_new_jmp) jmp_pending_d = 1'b1;
                end else if (bus.ex_new_jmp) begin
                    bubble_c  = 1'b1;
                    pc_load_c = 1'b1;
                    if (FLUSH_AFTER_JMP != 3'd0) begin
                        state_d = FLUSH;
                        fl_d    = FLUSH_AFTER_JMP;
                    end
                end
            end
            MEM_WAIT: begin
                en_fetch_c = 1'b0;
                en_dec_c   = 1'b0;
                tmo_d      = tmo_q + 8'd1;
                if (bus.lam_ack || (tmo_q == TMO_LAST)) begin
                    if (bus.lam_ack) begin
                        en_dec_c = 1'b1;
                        bubble_c = hz;
                    end else begin
                        mem_err_c = 1'b1;
                    end
                    lam_req_d = 1'b0;
                    tmo_d     = '0;
                    if (jmp_pending_q) begin
                        pc_load_c     = 1'b1;
                        jmp_pending_d = 1'b0;
                        state_d       = FLUSH;
                        fl_d          = FLUSH_AFTER_MEM;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            FLUSH: begin
                bubble_c = 1'b1;
                fl_d     = fl_q - 3'd1;
                if (fl_q <= 3'd1) begin
                    fl_d    = '0;
                    state_d = RUN;
                end
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= RUN;
            tmo_q         <= '0;
            fl_q          <= '0;
            jmp_pending_q <= 1'b0;
            lam_req_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            tmo_q         <= tmo_d;
            fl_q          <= fl_d;
            jmp_pending_q <= jmp_pending_d;
            lam_req_q     <= lam_req_d;
        end
    end

    // Every output is forced low while reset is held, including the combinational ones.
    assign bus.en_fetch    = ~reset & en_fetch_c;
    assign bus.en_dec      = ~reset & en_dec_c;
    assign bus.bubble      = ~reset & bubble_c;
    assign bus.pc_load_jmp = ~reset & pc_load_c;
    assign bus.mem_err     = ~reset & mem_err_c;
    assign bus.lam_req     = lam_req_q;
    assign bus.busy        = ~reset & (state_q != RUN);

`ifdef PIPE_HAZARD_PERF_CNT_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic [15:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (!bus.en_dec && (stall_cnt_q != 16'hFFFF)) stall_cnt_d = stall_cnt_q + 16'd1;
        if (bus.bubble && (flush_cnt_q != 16'hFFFF)) flush_cnt_d = flush_cnt_q + 16'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl; output vector is
// {en_fetch, en_dec, bubble, pc_load_jmp, lam_req, mem_err, busy}.
module tb_pipe_hazard_ctrl;
    localparam int RA_W = 6;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    typedef struct {
        logic            rst;
        logic            dv;
        logic [RA_W-1:0] sel_a;
        logic [4:0]      sel_b;
        logic            uses_b;
        logic [RA_W-1:0] sel_out;
        logic            lnew;
        logic            lload;
        logic            jmp;
        logic            ack;
        logic [6:0]      want;
    } stim_t;

    logic [6:0] sb[$];
    stim_t      seq[$];
    logic [6:0] obs;
    logic [6:0] want;

    pipe_hazard_ctrl_if #(.RA_W(RA_W)) bus ();

`ifdef PIPE_HAZARD_PERF_CNT_EN
    logic [15:0] stall_cnt;
    logic [15:0] flush_cnt;
`endif

    pipe_hazard_ctrl #(.FLUSH_CYCLES(2), .MEM_TIMEOUT(15), .RA_W(RA_W)) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
`ifdef PIPE_HAZARD_PERF_CNT_EN
        ,
        .stall_cnt(stall_cnt),
        .flush_cnt(flush_cnt)
`endif
    );

    always #5 clk = ~clk;

    function automatic stim_t mk(input logic rst, input logic dv, input int a, input int b,
                                 input logic ub, input int o, input logic ln, input logic ll,
                                 input logic j, input logic ack, input logic [6:0] w);
        stim_t s;
        s.rst = rst; s.dv = dv; s.sel_a = RA_W'(a); s.sel_b = 5'(b); s.uses_b = ub;
        s.sel_out = RA_W'(o); s.lnew = ln; s.lload = ll; s.jmp = j; s.ack = ack; s.want = w;
        return s;
    endfunction

    function automatic stim_t idle(input logic [6:0] w);
        return mk(0, 1, 1, 2, 0, 3, 0, 0, 0, 0, w);
    endfunction

    task automatic apply(input stim_t s);
        reset           = s.rst;
        bus.dec_valid   = s.dv;
        bus.dec_selA    = s.sel_a;
        bus.dec_selB    = s.sel_b;
        bus.dec_uses_b  = s.uses_b;
        bus.ex_selOut   = s.sel_out;
        bus.ex_lam_new  = s.lnew;
        bus.ex_lam_load = s.lload;
        bus.ex_new_jmp  = s.jmp;
        bus.lam_ack     = s.ack;
    endtask

    function automatic logic [6:0] outs();
        return {bus.en_fetch, bus.en_dec, bus.bubble, bus.pc_load_jmp,
                bus.lam_req, bus.mem_err, bus.busy};
    endfunction

    task automatic test_reset();
        seq.delete();
        seq.push_back(mk(1, 1, 5, 5, 1, 5, 1, 1, 1, 1, 7'b0000000));
        seq.push_back(mk(1, 1, 5, 5, 1, 5, 0, 0, 1, 0, 7'b0000000));
        for (int k = 0; k < 3; k++) seq.push_back(idle(7'b1100000));
        foreach (seq[i]) begin
            @(posedge clk); #1;
            apply(seq[i]);
            sb.push_back(seq[i].want);
            @(negedge clk);
            obs = outs();
            want = sb.pop_front();
            checks++;
            if (obs !== want) begin
                errors++;
                $display("[TB] FAIL reset cycle %0d: got %b expected %b", i, obs, want);
            end
        end
    endtask

    task automatic test_load_use();
        seq.delete();
        // Load r5, decode reads r5 via selA, ack on the third wait cycle.
        seq.push_back(mk(0, 1, 5, 0, 0, 5, 1, 1, 0, 0, 7'b0000000));
        seq.push_back(mk(0, 1, 5, 0, 0, 5, 1, 1, 0, 0, 7'b0000101));
        seq.push_back(mk(0, 1, 5, 0, 0, 5, 1, 1, 0, 0, 7'b0000101));
        seq.push_back(mk(0, 1, 5, 0, 0, 5, 1, 1, 0, 1, 7'b0110101));
        seq.push_back(idle(7'b1100000));
        // Hazard through selB.
        seq.push_back(mk(0, 1, 1, 5, 1, 5, 1, 1, 0, 0, 7'b0000000));
        seq.push_back(mk(0, 1, 1, 5, 1, 5, 1, 1, 0, 1, 7'b0110101));
        seq.push_back(idle(7'b1100000));
        // selB=1 zero-extends to 1, not 33.
        seq.push_back(mk(0, 1, 2, 1, 1, 33, 1, 1, 0, 0, 7'b0000000));
        seq.push_back(mk(0, 1, 2, 1, 1, 33, 1, 1, 0, 1, 7'b0100101));
        // Destination r0 never hazards.
        seq.push_back(mk(0, 1, 0, 0, 1, 0, 1, 1, 0, 0, 7'b0000000));
        seq.push_back(mk(0, 1, 0, 0, 1, 0, 1, 1, 0, 1, 7'b0100101));
        // Store, invalid decode, and selB match with uses_b=0 all skip the bubble.
        seq.push_back(mk(0, 1, 5, 0, 0, 5, 1, 0, 0, 0, 7'b0000000));
        seq.push_back(mk(0, 1, 5, 0, 0, 5, 1, 0, 0, 1, 7'b0100101));
        seq.push_back(mk(0, 0, 5, 0, 0, 5, 1, 1, 0, 0, 7'b0000000));
        seq.push_back(mk(0, 0, 5, 0, 0, 5, 1, 1, 0, 1, 7'b0100101));
        seq.push_back(mk(0, 1, 1, 5, 0, 5, 1, 1, 0, 0, 7'b0000000));
        seq.push_back(mk(0, 1, 1, 5, 0, 5, 1, 1, 0, 1, 7'b0100101));
        seq.push_back(idle(7'b1100000));
        foreach (seq[i]) begin
            @(posedge clk); #1;
            apply(seq[i]);
            sb.push_back(seq[i].want);
            @(negedge clk);
            obs = outs();
            want = sb.pop_front();
            checks++;
            if (obs !== want) begin
                errors++;
                $display("[TB] FAIL load_use cycle %0d: got %b expected %b", i, obs, want);
            end
        end
    endtask

    task automatic test_jump();
        seq.delete();
        seq.push_back(mk(0, 1, 1, 2, 0, 3, 0, 0, 1, 0, 7'b1111000));
        seq.push_back(idle(7'b1110001));
        seq.push_back(idle(7'b1100000));
        seq.push_back(idle(7'b1100000));
        foreach (seq[i]) begin
            @(posedge clk); #1;
            apply(seq[i]);
            sb.push_back(seq[i].want);
            @(negedge clk);
            obs = outs();
            want = sb.pop_front();
            checks++;
            if (obs !== want) begin
                errors++;
                $display("[TB] FAIL jump cycle %0d: got %b expected %b", i, obs, want);
            end
        end
    endtask

    task automatic test_mem_jmp();
        seq.delete();
        seq.push_back(mk(0, 1, 1, 2, 0, 3, 1, 0, 1, 0, 7'b0000000));
        seq.push_back(mk(0, 1, 1, 2, 0, 3, 1, 0, 1, 0, 7'b0000101));
        seq.push_back(mk(0, 1, 1, 2, 0, 3, 1, 0, 1, 1, 7'b0101101));
        seq.push_back(idle(7'b1110001));
        seq.push_back(idle(7'b1110001));
        seq.push_back(idle(7'b1100000));
        foreach (seq[i]) begin
            @(posedge clk); #1;
            apply(seq[i]);
            sb.push_back(seq[i].want);
            @(negedge clk);
            obs = outs();
            want = sb.pop_front();
            checks++;
            if (obs !== want) begin
                errors++;
                $display("[TB] FAIL mem_jmp cycle %0d: got %b expected %b", i, obs, want);
            end
        end
    endtask

    task automatic test_timeout();
        seq.delete();
        for (int r = 0; r < 2; r++) begin
            seq.push_back(mk(0, 1, 2, 0, 0, 7, 1, 1, 0, 0, 7'b0000000));
            // A stray jump mid-wait must not matter.
            for (int k = 0; k < 14; k++)
                seq.push_back(mk(0, 1, 2, 0, 0, 7, 1, 1, (k == 5), 0, 7'b0000101));
            if (r == 0) seq.push_back(mk(0, 1, 2, 0, 0, 7, 1, 1, 0, 0, 7'b0000111));
            else        seq.push_back(mk(0, 1, 2, 0, 0, 7, 1, 1, 0, 1, 7'b0100101));
            seq.push_back(idle(7'b1100000));
        end
        foreach (seq[i]) begin
            @(posedge clk); #1;
            apply(seq[i]);
            sb.push_back(seq[i].want);
            @(negedge clk);
            obs = outs();
            want = sb.pop_front();
            checks++;
            if (obs !== want) begin
                errors++;
                $display("[TB] FAIL timeout cycle %0d: got %b expected %b", i, obs, want);
            end
        end
    endtask

    task automatic test_back_to_back();
        seq.delete();
        seq.push_back(mk(0, 1, 1, 2, 0, 3, 0, 0, 1, 0, 7'b1111000));
        seq.push_back(mk(0, 1, 4, 2, 0, 4, 1, 1, 1, 1, 7'b1110001));
        seq.push_back(mk(0, 1, 9, 2, 0, 4, 1, 1, 0, 0, 7'b0000000));
        seq.push_back(mk(0, 1, 9, 2, 0, 4, 1, 1, 0, 1, 7'b0100101));
        seq.push_back(mk(0, 1, 1, 2, 0, 3, 0, 0, 0, 1, 7'b1100000));
        seq.push_back(mk(0, 1, 1, 2, 0, 3, 0, 0, 1, 0, 7'b1111000));
        seq.push_back(idle(7'b1110001));
        seq.push_back(idle(7'b1100000));
        foreach (seq[i]) begin
            @(posedge clk); #1;
            apply(seq[i]);
            sb.push_back(seq[i].want);
            @(negedge clk);
            obs = outs();
            want = sb.pop_front();
            checks++;
            if (obs !== want) begin
                errors++;
                $display("[TB] FAIL back_to_back cycle %0d: got %b expected %b", i, obs, want);
            end
        end
    endtask

    task automatic test_reset_midway();
        seq.delete();
        seq.push_back(mk(0, 1, 5, 0, 0, 5, 1, 1, 0, 0, 7'b0000000));
        seq.push_back(mk(0, 1, 5, 0, 0, 5, 1, 1, 0, 0, 7'b0000101));
        seq.push_back(mk(1, 1, 5, 0, 0, 5, 1, 1, 0, 0, 7'b0000000));
        seq.push_back(mk(1, 1, 5, 0, 0, 5, 1, 1, 1, 0, 7'b0000000));
        seq.push_back(idle(7'b1100000));
        foreach (seq[i]) begin
            @(posedge clk); #1;
            apply(seq[i]);
            sb.push_back(seq[i].want);
            @(negedge clk);
            obs = outs();
            want = sb.pop_front();
            checks++;
            if (obs !== want) begin
                errors++;
                $display("[TB] FAIL reset_midway cycle %0d: got %b expected %b", i, obs, want);
            end
        end
`ifdef PIPE_HAZARD_PERF_CNT_EN
        checks++;
        if ((stall_cnt !== 16'd0) || (flush_cnt !== 16'd0)) begin
            errors++;
            $display("[TB] FAIL perf_cnt_after_reset: got stall=%0d flush=%0d expected 0 0",
                     stall_cnt, flush_cnt);
        end
`endif
        seq.push_back(idle(7'b1100000));
        seq.push_back(idle(7'b1100000));
        foreach (seq[i]) begin
            if (i < 5) continue;
            @(posedge clk); #1;
            apply(seq[i]);
            sb.push_back(seq[i].want);
            @(negedge clk);
            obs = outs();
            want = sb.pop_front();
            checks++;
            if (obs !== want) begin
                errors++;
                $display("[TB] FAIL after_reset cycle %0d: got %b expected %b", i, obs, want);
            end
        end
    endtask

    initial begin
        apply(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 7'b0000000));
        test_reset();
        test_load_use();
        test_jump();
        test_mem_jmp();
        test_timeout();
        test_back_to_back();
        test_reset_midway();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
